// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the serial subtractor and the parallel adder bench:
// FSM state encodings and default operand/counter widths.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CW    = 3;

endpackage

// File: rtl/serial_subtractor_fsub_cell.sv
// 1-bit combinational full subtractor (x - y - bin), built from
// xor/and/or terms in the same gate style as the adder cells.
module fsub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic x_n;
  logic x_xor_y;
  logic g_ny;
  logic g_nb;
  logic g_yb;

  assign x_n     = ~x;
  assign x_xor_y = x ^ y;
  assign diff    = x_xor_y ^ bin;

  // Borrow out whenever the subtrahend side outweighs the minuend bit.
  assign g_ny = x_n & y;
  assign g_nb = x_n & bin;
  assign g_yb = y & bin;
  assign bout = g_ny | g_nb | g_yb;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bi, LSB first through one fsub_cell and a borrow flop;
// result valid WIDTH cycles after the accepting edge, start ignored while busy.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             busy_q;
  logic             done_q;

  logic             diff;
  logic             bout;
  logic [WIDTH-1:0] r_d;
  logic             last_bit;

  fsub_cell u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (br_q),
    .diff (diff),
    .bout (bout)
  );

  assign r_d      = {diff, r_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts a new start exactly like IDLE, giving back-to-back ops.
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bi;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          br_q  <= bout;
          r_q   <= r_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            d_q     <= r_d;
            bo_q    <= bout;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=4): latency, handshake,
// ignored mid-run start, back-to-back ops and reset abort.
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bi;
  logic [3:0] d;
  logic       bo;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  serial_subtractor #(.WIDTH(4), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .d     (d),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for one edge; returns just after the accepting edge.
  task automatic do_start(input logic [3:0] av, input logic [3:0] bv, input logic biv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    bi    = biv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done is seen; -1 if it never arrives.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a = 4'hF; b = 4'h1; bi = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({d, bo, busy, done} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got d=%h bo=%b busy=%b done=%b, want all 0", d, bo, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overrides_start: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_zero_handshake();
    do_start(4'h0, 4'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_busy_c%0d: busy=%b done=%b, want busy=1 done=0", i, busy, done);
      end
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || d !== 4'h0 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_result: done=%b busy=%b d=%h bo=%b, want 1 0 0 0", done, busy, d, bo);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_arith();
    logic [3:0] ta [4] = '{4'h9, 4'h2, 4'h0, 4'hF};
    logic [3:0] tb [4] = '{4'h3, 4'h7, 4'hF, 4'h3};
    logic       tbi[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] td [4] = '{4'h5, 4'hB, 4'h0, 4'hC};
    logic       tbo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int cyc;
    for (int k = 0; k < 4; k++) begin
      do_start(ta[k], tb[k], tbi[k]);
      wait_done(cyc);
      vectors++;
      if (cyc !== 4 || d !== td[k] || bo !== tbo[k]) begin
        miscompares++;
        $display("FAIL arith_%0d: lat=%0d d=%h bo=%b, want lat=4 d=%h bo=%b",
                 k, cyc, d, bo, td[k], tbo[k]);
      end
      @(negedge clk);
      vectors++;
      if (d !== td[k] || bo !== tbo[k] || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL arith_hold_%0d: d=%h bo=%b busy=%b, want d=%h bo=%b busy=0",
                 k, d, bo, busy, td[k], tbo[k]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    do_start(4'h8, 4'h1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 4'h0; b = 4'h0; bi = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = -1;
    for (int i = 3; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    vectors++;
    if (cyc !== 4 || d !== 4'h7 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: lat=%0d d=%h bo=%b, want lat=4 d=7 bo=0", cyc, d, bo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_start(4'h6, 4'h2, 1'b0);
    wait_done(cyc);
    vectors++;
    if (cyc !== 4 || d !== 4'h4 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d d=%h bo=%b, want lat=4 d=4 bo=0", cyc, d, bo);
    end
    start = 1'b1;
    a = 4'h5; b = 4'h5; bi = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_bubble: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    wait_done(cyc);
    vectors++;
    if (cyc !== 4 || d !== 4'h0 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d d=%h bo=%b, want lat=4 d=0 bo=0", cyc, d, bo);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    int seen;
    do_start(4'h9, 4'h3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({d, bo, busy, done} !== 7'b0) begin
      miscompares++;
      $display("FAIL abort_clear: d=%h bo=%b busy=%b done=%b, want all 0", d, bo, busy, done);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: %0d active cycles after abort, want 0", seen);
    end
    do_start(4'hA, 4'h4, 1'b0);
    wait_done(cyc);
    vectors++;
    if (cyc !== 4 || d !== 4'h6 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_restart: lat=%0d d=%h bo=%b, want lat=4 d=6 bo=0", cyc, d, bo);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    start = 1'b0;
    a = 4'h0; b = 4'h0; bi = 1'b0;
    test_reset();
    test_zero_handshake();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
